down_cnt8b_timer: RTL and testbench

- Loadable 8-bit down counter/timer; the counting counterpart to the 8-bit up counter in the same chapter.
- Software or an upstream FSM loads a count and gates counting with SS.
- The block counts to zero, then either raises a terminal-count pulse and a done flag, or auto-reloads for periodic ticks.
- Used as a one-shot delay or baud/tick generator alongside the up counter.

---
 rtl/down_cnt8b_timer_pkg.sv | 18 +
 rtl/down_cnt8b_timer.sv | 110 +++++++++++
 tb/tb_down_cnt8b_timer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/down_cnt8b_timer_pkg.sv
// Shared definitions for the loadable down counter/timer: state encoding,
// default width and the busy decode used by the top.
package down_cnt8b_timer_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic is_busy(input state_t st);
    return (st == ST_RUN) || (st == ST_PAUSE);
  endfunction

endpackage

// File: rtl/down_cnt8b_timer.sv
// Loadable down counter/timer with one-shot (sticky done) or periodic reload.
//   state | meaning
//   IDLE  | loaded or cleared, waiting for SS with a nonzero count
//   RUN   | decrementing while SS is high
//   PAUSE | SS dropped mid-count, OUT held
//   DONE  | one-shot finished, OUT = 0, done held until load/clr/reset
module down_cnt8b_timer
  import down_cnt8b_timer_pkg::*;
#(
  parameter int unsigned           WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SS,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  input  logic             clr,
  output logic [WIDTH-1:0] OUT,
  output logic             tc,
  output logic             done,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;
  logic             r_done;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_out_nxt;
  logic [WIDTH-1:0] w_reload_nxt;
  logic             w_tc_nxt;
  logic             w_done_nxt;

  always_comb begin
    w_state_nxt  = r_state;
    w_out_nxt    = r_out;
    w_reload_nxt = r_reload;
    w_tc_nxt     = 1'b0;
    w_done_nxt   = r_done;
    if (load) begin
      w_out_nxt    = load_val;
      w_reload_nxt = load_val;
      w_done_nxt   = 1'b0;
      w_state_nxt  = ST_IDLE;
    end else if (clr) begin
      w_done_nxt  = 1'b0;
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (SS && (r_out != '0)) w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (!SS) begin
            w_state_nxt = ST_PAUSE;
          end else if (r_out > ONE) begin
            w_out_nxt = r_out - ONE;
          end else if (r_out == ONE) begin
            // Terminal count: 1 goes to reload or 0, never wraps to all-ones
            w_tc_nxt = 1'b1;
            if (auto_reload) begin
              w_out_nxt = r_reload;
            end else begin
              w_out_nxt   = '0;
              w_done_nxt  = 1'b1;
              w_state_nxt = ST_DONE;
            end
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_PAUSE: begin
          if (SS) w_state_nxt = ST_RUN;
        end
        ST_DONE: begin
          w_state_nxt = ST_DONE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_out    <= RESET_VAL;
      r_reload <= RESET_VAL;
      r_tc     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_out    <= w_out_nxt;
      r_reload <= w_reload_nxt;
      r_tc     <= w_tc_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign OUT  = r_out;
  assign tc   = r_tc;
  assign done = r_done;
  assign busy = is_busy(r_state);

endmodule

// File: tb/tb_down_cnt8b_timer.sv
// Scoreboard bench for down_cnt8b_timer: a driver predicts each edge's outcome
// into a queue, a monitor pops and compares after every rising edge.
module tb_down_cnt8b_timer;

  logic       clk;
  logic       rst;
  logic       SS;
  logic       load;
  logic [7:0] load_val;
  logic       auto_reload;
  logic       clr;
  logic [7:0] OUT;
  logic       tc;
  logic       done;
  logic       busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] out;
    logic       tc;
    logic       done;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: a count session is either absent, counting or on hold;
  // 'finished' is the one-shot completion flag.
  int unsigned m_out, m_reload;
  bit m_tc, m_finished, m_session, m_hold;

  down_cnt8b_timer #(.WIDTH(8), .RESET_VAL(8'd0)) dut (
    .clk(clk), .rst(rst), .SS(SS), .load(load), .load_val(load_val),
    .auto_reload(auto_reload), .clr(clr), .OUT(OUT), .tc(tc), .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_out = 0; m_reload = 0; m_tc = 0; m_finished = 0; m_session = 0; m_hold = 0;
  endtask

  task automatic model_step(input bit ss, input bit ld, input int unsigned lv,
                            input bit ar, input bit cl);
    m_tc = 0;
    if (ld) begin
      m_out = lv; m_reload = lv; m_finished = 0; m_session = 0; m_hold = 0;
    end else if (cl) begin
      m_finished = 0; m_session = 0; m_hold = 0;
    end else if (m_finished) begin
      m_finished = 1;
    end else if (!m_session) begin
      if (ss && m_out != 0) begin m_session = 1; m_hold = 0; end
    end else if (!ss) begin
      m_hold = 1;
    end else if (m_hold) begin
      m_hold = 0;
    end else if (m_out > 1) begin
      m_out = m_out - 1;
    end else begin
      m_tc = 1;
      if (ar) m_out = m_reload;
      else begin m_out = 0; m_finished = 1; m_session = 0; end
    end
  endtask

  task automatic cyc(input bit ss, input bit ld, input logic [7:0] lv,
                     input bit ar, input bit cl);
    exp_t e;
    @(negedge clk);
    SS = ss; load = ld; load_val = lv; auto_reload = ar; clr = cl;
    model_step(ss, ld, int'(lv), ar, cl);
    e.out = m_out[7:0]; e.tc = m_tc; e.done = m_finished; e.busy = m_session;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rst === 1'b1 && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (OUT !== e.out || tc !== e.tc || done !== e.done || busy !== e.busy) begin
        errors++;
        $display("FAIL edge_check t=%0t: got OUT=%0d tc=%b done=%b busy=%b, expected OUT=%0d tc=%b done=%b busy=%b",
                 $time, OUT, tc, done, busy, e.out, e.tc, e.done, e.busy);
      end
    end
  end

  initial begin
    bit ar_r;
    rst = 1'b0; SS = 0; load = 0; load_val = 0; auto_reload = 0; clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", OUT, 8'd0);
    chk("reset_flags", {5'd0, tc, done, busy}, 8'd0);
    @(negedge clk) rst = 1'b1;

    // One-shot from 3, then load+clr together in DONE
    cyc(0, 1, 8'd3, 0, 0);
    repeat (6) cyc(1, 0, 8'd0, 0, 0);
    cyc(1, 1, 8'd7, 0, 1);
    repeat (10) cyc(1, 0, 8'd0, 0, 0);
    cyc(0, 0, 8'd0, 0, 1);
    repeat (2) cyc(1, 0, 8'd0, 0, 0);

    // Periodic from 2
    cyc(0, 1, 8'd2, 1, 0);
    repeat (8) cyc(1, 0, 8'd0, 1, 0);

    // Pause at 2 for three cycles, then resume to completion
    cyc(0, 1, 8'd4, 0, 0);
    repeat (3) cyc(1, 0, 8'd0, 0, 0);
    repeat (3) cyc(0, 0, 8'd0, 0, 0);
    repeat (5) cyc(1, 0, 8'd0, 0, 0);

    // Mid-run load, then zero start
    cyc(0, 1, 8'd7, 0, 0);
    repeat (3) cyc(1, 0, 8'd0, 0, 0);
    cyc(1, 1, 8'd9, 0, 0);
    cyc(1, 1, 8'd0, 0, 0);
    repeat (3) cyc(1, 0, 8'd0, 0, 0);
    cyc(1, 0, 8'd0, 1, 0);

    // Async reset mid-run with OUT = 5
    cyc(0, 1, 8'd8, 0, 0);
    repeat (4) cyc(1, 0, 8'd0, 0, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_out", OUT, 8'd0);
    chk("async_rst_tc", {7'd0, tc}, 8'd0);
    chk("async_rst_done", {7'd0, done}, 8'd0);
    chk("async_rst_busy", {7'd0, busy}, 8'd0);
    exp_q.delete();
    model_reset();
    @(posedge clk);
    @(negedge clk) rst = 1'b1;

    ar_r = 0;
    for (int i = 0; i < 3000; i++) begin
      bit ss_r, ld_r, cl_r;
      logic [7:0] lv_r;
      ss_r = ($urandom_range(0, 99) < 80);
      ld_r = ($urandom_range(0, 24) == 0);
      cl_r = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) ar_r = ~ar_r;
      lv_r = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                         : 8'($urandom_range(0, 9));
      cyc(ss_r, ld_r, lv_r, ar_r, cl_r);
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
